// File: rtl/fifo_vc.sv
// First-word-fall-through FIFO feeding one virtual-channel input of the routing arbiter.
// Optional macro FIFO_THRESH_EN enables the almost_full/almost_empty threshold flags.
module fifo_vc #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 2,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                 DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  error_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  pop_ok_s;
    logic                  push_ok_s;
    logic                  overflow_s;
    logic                  underflow_s;

    // Acceptance decode; a full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        empty_s     = (count_r == {(ADDR_WIDTH + 1){1'b0}});
        full_s      = (count_r == DEPTH_CNT);
        pop_ok_s    = pop & ~empty_s;
        push_ok_s   = push & (~full_s | pop_ok_s);
        underflow_s = pop & empty_s;
        overflow_s  = push & full_s & ~pop_ok_s;
    end

    // Storage array; intentionally not reset, stale words are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and sticky error.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= {(ADDR_WIDTH + 1){1'b0}};
            error_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            error_r <= error_r | overflow_s | underflow_s;
        end
    end

    // Head word and status flags.
    always_comb begin
        data_out = {DATA_WIDTH{1'b0}};
        if (empty_s) begin
            data_out = {DATA_WIDTH{1'b0}};
        end else begin
            data_out = mem_r[rd_ptr_r];
        end
        empty = empty_s;
        full  = full_s;
        error = error_r;
    end

`ifdef FIFO_THRESH_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = ALMOST_FULL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT = ALMOST_EMPTY[ADDR_WIDTH:0];

    // Threshold flags from the registered occupancy.
    always_comb begin
        almost_full  = (count_r >= AF_CNT);
        almost_empty = (count_r <= AE_CNT);
    end
`else
    // Thresholds only feed a constant sink here so the build keeps no compare logic.
    logic unused_thresh_s;
    assign unused_thresh_s = ALMOST_FULL[0] ^ ALMOST_EMPTY[0];

    // Threshold flags disabled in this build.
    always_comb begin
        almost_full  = 1'b0;
        almost_empty = 1'b0;
    end
`endif

endmodule

// File: tb/tb_fifo_vc.sv
// Self-checking bench for fifo_vc: a queue scoreboard models stored words, flags and sticky error.
module tb_fifo_vc;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int         checks;
    int         errors;
    logic [5:0] sb_q[$];
    logic       err_m;
    logic [5:0] exp_pop;
    logic [5:0] got_pop;
    logic       pop_seen;

    fifo_vc dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {empty, full, almost_full, almost_empty, error} from the model.
    function automatic logic [4:0] exp_flags();
        int   n;
        logic af;
        logic ae;
        n  = sb_q.size();
        af = 1'b0;
        ae = 1'b0;
`ifdef FIFO_THRESH_EN
        af = (n >= 3);
        ae = (n <= 1);
`endif
        return {(n == 0), (n == DEPTH), af, ae, err_m};
    endfunction

    function automatic logic [5:0] exp_head();
        if (sb_q.size() == 0) return 6'h00;
        return sb_q[0];
    endfunction

    // Drive one clock cycle and update the scoreboard with what the FIFO must accept.
    task automatic cycle(input logic p, input logic [5:0] d, input logic q);
        logic emp;
        logic ful;
        logic pok;
        logic hok;
        @(negedge clk);
        push    = p;
        data_in = d;
        pop     = q;
        #1;
        emp = (sb_q.size() == 0);
        ful = (sb_q.size() == DEPTH);
        pok = q & ~emp;
        hok = p & (~ful | pok);
        if ((q & emp) | (p & ful & ~pok)) err_m = 1'b1;
        pop_seen = 1'b0;
        if (pok) begin
            exp_pop  = sb_q.pop_front();
            got_pop  = data_out;
            pop_seen = 1'b1;
        end
        if (hok) sb_q.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        sb_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 6'h00;
        reset_L = 1'b0;
        sb_q.delete();
        err_m = 1'b0;
        #2;
        checks++;
        if ({empty, full, almost_full, almost_empty, error} !== exp_flags()) begin
            errors++;
            $display("FAIL reset_flags got %b want %b", {empty, full, almost_full, almost_empty, error}, exp_flags());
        end
        checks++;
        if (data_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", data_out);
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_fill();
        logic [5:0] words [4];
        words = '{6'h15, 6'h2A, 6'h3F, 6'h01};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, words[i], 1'b0);
            checks++;
            if ({empty, full, almost_full, almost_empty, error} !== exp_flags()) begin
                errors++;
                $display("FAIL fill_flags[%0d] got %b want %b", i, {empty, full, almost_full, almost_empty, error}, exp_flags());
            end
            checks++;
            if (data_out !== 6'h15) begin
                errors++;
                $display("FAIL fill_head[%0d] got %h want 15", i, data_out);
            end
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got %b want 1", full);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
            checks++;
            if (got_pop !== exp_pop) begin
                errors++;
                $display("FAIL drain_word[%0d] got %h want %h", i, got_pop, exp_pop);
            end
            checks++;
            if ({empty, full, almost_full, almost_empty, error} !== exp_flags()) begin
                errors++;
                $display("FAIL drain_flags[%0d] got %b want %b", i, {empty, full, almost_full, almost_empty, error}, exp_flags());
            end
        end
        checks++;
        if ({data_out, empty, error} !== {6'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drain_end got data %h empty %b error %b want 00 1 0", data_out, empty, error);
        end
    endtask

    task automatic test_full_push_pop();
        cycle(1'b1, 6'h15, 1'b0);
        cycle(1'b1, 6'h2A, 1'b0);
        cycle(1'b1, 6'h3F, 1'b0);
        cycle(1'b1, 6'h01, 1'b0);
        cycle(1'b1, 6'h07, 1'b1);
        checks++;
        if (got_pop !== 6'h15) begin
            errors++;
            $display("FAIL fullpp_pop got %h want 15", got_pop);
        end
        checks++;
        if ({full, error, data_out} !== {1'b1, 1'b0, 6'h2A}) begin
            errors++;
            $display("FAIL fullpp_state got full %b error %b head %h want 1 0 2a", full, error, data_out);
        end
        test_drain();
        checks++;
        if (exp_pop !== 6'h07) begin
            errors++;
            $display("FAIL fullpp_tail got %h want 07", exp_pop);
        end
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b1, 6'h0C, 1'b1);
        checks++;
        if ({empty, error, data_out} !== {1'b0, 1'b1, 6'h0C}) begin
            errors++;
            $display("FAIL emptypp got empty %b error %b head %h want 0 1 0c", empty, error, data_out);
        end
        cycle(1'b0, 6'h00, 1'b1);
        checks++;
        if ({empty, error, got_pop} !== {1'b1, 1'b1, 6'h0C}) begin
            errors++;
            $display("FAIL emptypp_drain got empty %b error %b word %h want 1 1 0c", empty, error, got_pop);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i + 8), 1'b0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre got error %b want 0", error);
        end
        cycle(1'b1, 6'h33, 1'b0);
        checks++;
        if ({full, error, data_out} !== {1'b1, 1'b1, 6'h08}) begin
            errors++;
            $display("FAIL ovf got full %b error %b head %h want 1 1 08", full, error, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
            checks++;
            if (got_pop !== exp_pop) begin
                errors++;
                $display("FAIL ovf_drain[%0d] got %h want %h", i, got_pop, exp_pop);
            end
        end
        checks++;
        if ({empty, error} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_sticky got empty %b error %b want 1 1", empty, error);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i + 20), 1'b0);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b1, 6'h18, 1'b0);
        cycle(1'b1, 6'h19, 1'b0);
        checks++;
        if ({full, data_out} !== {1'b1, 6'h16}) begin
            errors++;
            $display("FAIL wrap got full %b head %h want 1 16", full, data_out);
        end
        cycle(1'b1, 6'h3A, 1'b0);
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        sb_q.delete();
        err_m = 1'b0;
        #1;
        checks++;
        if ({empty, full, error, data_out} !== {1'b1, 1'b0, 1'b0, 6'h00}) begin
            errors++;
            $display("FAIL async_rst got empty %b full %b error %b head %h want 1 0 0 00", empty, full, error, data_out);
        end
        @(negedge clk);
        reset_L = 1'b1;
        cycle(1'b1, 6'h2B, 1'b0);
        checks++;
        if ({empty, data_out} !== {1'b0, 6'h2B}) begin
            errors++;
            $display("FAIL post_rst_head got empty %b head %h want 0 2b", empty, data_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            if (pop_seen) begin
                checks++;
                if (got_pop !== exp_pop) begin
                    errors++;
                    $display("FAIL rnd_pop[%0d] got %h want %h", i, got_pop, exp_pop);
                end
            end
            checks++;
            if ({empty, full, almost_full, almost_empty, error, data_out} !== {exp_flags(), exp_head()}) begin
                errors++;
                $display("FAIL rnd_state[%0d] got %b/%h want %b/%h", i,
                         {empty, full, almost_full, almost_empty, error}, data_out, exp_flags(), exp_head());
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        err_m    = 1'b0;
        pop_seen = 1'b0;
        exp_pop  = 6'h00;
        got_pop  = 6'h00;
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_overflow();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_vc.md
FIFO_VC -- requirements
Module: fifo_vc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6: width of one word, matching the VC0/VC1 words the routing arbiter consumes.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2: storage depth is 2**ADDR_WIDTH words (4).
REQ-003 The block SHALL have parameter ALMOST_FULL, default 3: occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter ALMOST_EMPTY, default 1: occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port push, input, 1 bit: write request for data_in.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits: word to store.
REQ-009 The block SHALL have port pop, input, 1 bit: read request; driven by the arbiter's VCx_pop.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH bits: head word; drives the arbiter's VCx input.
REQ-011 The block SHALL have port empty, output, 1 bit: occupancy == 0; drives the arbiter's VCx_empty.
REQ-012 The block SHALL have port full, output, 1 bit: occupancy == 2**ADDR_WIDTH.
REQ-013 The block SHALL have ports almost_full and almost_empty, output, 1 bit each: threshold flags.
REQ-014 The block SHALL have port error, output, 1 bit: sticky overflow/underflow indicator.

Function
REQ-015 The block SHALL keep the write pointer and read pointer at ADDR_WIDTH bits, wrapping modulo the depth, and the occupancy counter at ADDR_WIDTH+1 bits.
REQ-016 The block SHALL behave as first-word-fall-through: data_out = mem[rd_ptr] combinationally while not empty, and all-zero while empty.
REQ-017 A push SHALL be accepted at a rising edge when push=1 and either full=0 or pop is accepted in the same cycle; the word is written at wr_ptr, then wr_ptr increments.
REQ-018 A pop SHALL be accepted at a rising edge when pop=1 and empty=0; rd_ptr increments, and the next word is visible on data_out after that edge.
REQ-019 Occupancy SHALL change as follows: +1 on push only, -1 on pop only, unchanged on accepted push and pop together.
REQ-020 Push and pop in the same cycle while empty SHALL accept the push only; the pop is ignored and flagged as underflow.
REQ-021 Push and pop in the same cycle while full SHALL accept both; full stays at 1 and the popped word is the old head.
REQ-022 Push while full without pop SHALL drop data_in, leave pointers unchanged, and set error.
REQ-023 Pop while empty SHALL leave pointers unchanged and set error.
REQ-024 Once set, error SHALL stay at 1 until reset.
REQ-025 empty, full, almost_full and almost_empty SHALL be decoded combinationally from the registered occupancy, so flags update in the same cycle occupancy changes, with no extra latency.

Reset
REQ-026 reset_L=0 SHALL immediately, without waiting for clk, clear the pointers, occupancy and error.
REQ-027 During reset, outputs SHALL be: empty=1, almost_empty=1, full=0, almost_full=0, error=0, data_out=0.
REQ-028 Memory contents SHALL NOT be required to reset; stale words are never visible because data_out is zero while empty.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the first push after release is the next head.

Configuration
REQ-030 The block SHALL support macro FIFO_THRESH_EN.
REQ-031 With FIFO_THRESH_EN defined, almost_full and almost_empty SHALL follow REQ-003/REQ-004.
REQ-032 Without FIFO_THRESH_EN, almost_full and almost_empty SHALL be tied to 0 and their threshold compare logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 Reset, then push 0x15, 0x2A, 0x3F, 0x01 on consecutive cycles -> full=1 after the 4th edge; data_out=0x15 throughout; almost_full=1 from occupancy 3.
REQ-034 From full, pop 4 times -> data_out sequence is 0x15, 0x2A, 0x3F, 0x01; empty=1 after the 4th pop; data_out=0; error=0.
REQ-035 Full FIFO, push 0x07 with pop -> head 0x15 leaves, 0x07 is stored at the tail, full stays 1, error=0.
REQ-036 Empty FIFO, push 0x0C with pop -> empty=0, data_out=0x0C next cycle, error=1 (underflow).
REQ-037 Fill 6 words (with pointer wrap after 2 pops), then reset_L low mid-cycle -> empty=1 and error=0 immediately, with no clock edge required.
REQ-038 Build without FIFO_THRESH_EN, run the REQ-033 sequence -> almost_full and almost_empty are 0 throughout, and all other responses are identical.
